stopwatch_lap_ctrl: RTL and testbench
=====================================

# stopwatch_lap_ctrl

Two-button sequencer for the stopwatch timer datapath. It turns a start/stop button and a lap/reset button into the timer's `start`/`stop`/`reset` pulses. While running, it captures lap times from the timer's `count` into a small first-word-fall-through FIFO that a downstream consumer drains over a valid/ready interface. It sits between the button front-end and the stopwatch counter instance.

## Interface
- `DATA_WIDTH`, 16: width of timer count and lap entries.
- `MAX`, 99: terminal value of the controlled timer; must match the timer instance.
- `LAP_DEPTH`, 4: lap FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock, all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `btn_ss`  in  1  start/stop button, one-cycle pulse.
- `btn_lr`  in  1  lap/reset button, one-cycle pulse.
- `sw_count`  in  DATA_WIDTH  current timer count.
- `sw_start`  out  1  timer start pulse.
- `sw_stop`  out  1  timer stop pulse.
- `sw_reset`  out  1  timer reset (active-high).
- `running`  out  1  high while in RUN.
- `lap_valid`  out  1  FIFO non-empty.
- `lap_data`  out  DATA_WIDTH  FIFO head entry.
- `lap_ready`  in  1  consumer pops head when `lap_valid & lap_ready`.
- `lap_count`  out  $clog2(LAP_DEPTH+1)  current FIFO occupancy.
- `lap_overflow`  out  1  sticky; a lap was dropped because the FIFO was full.

## Operation
- States: IDLE, RUN, PAUSE. Reset state is IDLE.
- IDLE:
  - `btn_lr` → reset action; stay IDLE.
  - else `btn_ss` → start pulse; go to RUN.
- RUN:
  - `btn_lr` → lap capture.
  - `btn_ss` → stop pulse; go to PAUSE.
  - Both in the same cycle → lap capture and stop pulse; go to PAUSE.
- PAUSE:
  - `btn_lr` → reset action; go to IDLE. Takes priority over `btn_ss`; `btn_ss` is ignored that cycle.
  - else `btn_ss` → start pulse; go to RUN.
- Reset action:
  - One-cycle `sw_reset` pulse.
  - FIFO flushed at the same edge; a concurrent pop is discarded.
  - `lap_overflow` cleared.
  - Last-lap register cleared to 0.
- Lap capture:
  - Entry is computed from `sw_count` sampled in the button cycle.
  - Push when not full, or when full and a pop occurs in the same cycle.
  - Otherwise the entry is dropped and `lap_overflow` is set.
  - Last-lap register is updated to `sw_count` on every capture, dropped or not.
- FIFO:
  - Simultaneous push and pop at any occupancy leaves `lap_count` unchanged.
  - A pop on an empty FIFO is ignored.
- `sw_start`, `sw_stop` and the button-driven `sw_reset` are mutually exclusive.

## Timing
- `sw_start`, `sw_stop`, `running`, `lap_*` are registered.
- `sw_reset` = `~resetn | rst_pulse_q`, so the timer is held cleared while `resetn` is low.
- Reset values: `sw_start`=0, `sw_stop`=0, `running`=0, `lap_valid`=0, `lap_data`=0, `lap_count`=0, `lap_overflow`=0. `sw_reset`=1 while `resetn` is low.
- Button sampled at edge E → the corresponding `sw_*` pulse is high for exactly the cycle after E.
- `running` changes in the cycle after E.
- Lap pushed at edge E → `lap_valid`/`lap_data` visible in the cycle after E; `lap_count` updates at E.
- Pop at edge E → the next head is presented in the cycle after E.
- Buttons held high are treated as a pulse every cycle; no edge detection is performed.

## Configuration
- Macro: `STOPWATCH_LAP_SPLIT_EN`.
- Defined:
  - Entry = split time = (`sw_count` − last_lap) mod (MAX+1).
  - If `sw_count` ≥ last_lap, the entry is the plain difference.
  - Otherwise the entry is `sw_count` + MAX + 1 − last_lap, computed in DATA_WIDTH+1 bits.
  - Splits longer than MAX+1 cycles alias.
- Undefined: entry = absolute `sw_count`. The last-lap register and subtractor are not built.

## Test plan
- Reset and start: `resetn`=0 for 2 cycles → `sw_reset`=1, all other outputs 0. Release, then `btn_ss` at edge E → `sw_start`=1 in the cycle after E only; `running`=1 from then.
- Absolute lap (macro off): in RUN, `btn_lr` with `sw_count`=37 → `lap_valid`=1 and `lap_data`=37 in the next cycle, `lap_count`=1. Pop with `lap_ready`=1 → `lap_valid`=0.
- Split lap (macro on, MAX=99): laps at counts 37 then 12 → entries 37, then 75.
- Overflow: `lap_ready`=0, 5 laps at counts 10, 20, 30, 40, 50 → `lap_count`=4, `lap_overflow`=1, drained entries are 10, 20, 30, 40. A lap pushed while full with `lap_ready`=1 in the same cycle is accepted with no overflow.
- Simultaneous buttons in RUN with `sw_count`=50 → lap 50 pushed, single `sw_stop` pulse, state PAUSE, `running`=0.
- Simultaneous buttons in PAUSE with 2 laps queued and overflow set → single `sw_reset` pulse, no `sw_start`, `lap_valid`=0, `lap_count`=0, `lap_overflow`=0, state IDLE.

Source files
------------

// File: rtl/stopwatch_lap_ctrl.sv
// rtl/stopwatch_lap_ctrl.sv - two-button stopwatch sequencer with lap FIFO (split laps: STOPWATCH_LAP_SPLIT_EN)
module stopwatch_lap_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX        = 99,
  parameter int LAP_DEPTH  = 4
) (
  input  logic                           clk_i,
  input  logic                           resetn_i,
  input  logic                           btn_ss_i,
  input  logic                           btn_lr_i,
  input  logic [DATA_WIDTH-1:0]          sw_count_i,
  output logic                           sw_start_o,
  output logic                           sw_stop_o,
  output logic                           sw_reset_o,
  output logic                           running_o,
  output logic                           lap_valid_o,
  output logic [DATA_WIDTH-1:0]          lap_data_o,
  input  logic                           lap_ready_i,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count_o,
  output logic                           lap_overflow_o
);

  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = $clog2(LAP_DEPTH+1);

  if (LAP_DEPTH < 2 || (LAP_DEPTH & (LAP_DEPTH - 1)) != 0 || MAX < 1) begin : g_bad_cfg
    $error("stopwatch_lap_ctrl: LAP_DEPTH must be a power of two >= 2 and MAX >= 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  state_e                state_q;
  logic                  start_q, stop_q, rst_pulse_q, running_q;
  logic [DATA_WIDTH-1:0] mem_q [LAP_DEPTH];
  logic [AW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  overflow_q;

  logic                  lap_req, reset_req, pop, full, push, drop;
  logic [DATA_WIDTH-1:0] lap_entry;

  always_comb begin
    lap_req   = (state_q == RUN) && btn_lr_i;
    reset_req = (state_q != RUN) && btn_lr_i;
    pop       = (count_q != '0) && lap_ready_i;
    full      = (count_q == CW'(LAP_DEPTH));
    push      = lap_req && (!full || pop);
    drop      = lap_req && !push;
  end

`ifdef STOPWATCH_LAP_SPLIT_EN
  logic [DATA_WIDTH-1:0] last_lap_q;
  logic [DATA_WIDTH:0]   wrap_sum;

  // Wrapped split: the timer rolled over MAX since the previous lap.
  always_comb begin
    wrap_sum = {1'b0, sw_count_i} + (DATA_WIDTH+1)'(MAX) + (DATA_WIDTH+1)'(1) - {1'b0, last_lap_q};
    if (sw_count_i >= last_lap_q) lap_entry = sw_count_i - last_lap_q;
    else                          lap_entry = DATA_WIDTH'(wrap_sum);
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i || reset_req) last_lap_q <= '0;
    else if (lap_req)           last_lap_q <= sw_count_i;
  end
`else
  always_comb lap_entry = sw_count_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      rst_pulse_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      rst_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_lr_i) begin
            rst_pulse_q <= 1'b1;
          end else if (btn_ss_i) begin
            start_q   <= 1'b1;
            running_q <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (btn_ss_i) begin
            stop_q    <= 1'b1;
            running_q <= 1'b0;
            state_q   <= PAUSE;
          end
        end
        PAUSE: begin
          if (btn_lr_i) begin
            rst_pulse_q <= 1'b1;
            state_q     <= IDLE;
          end else if (btn_ss_i) begin
            start_q   <= 1'b1;
            running_q <= 1'b1;
            state_q   <= RUN;
          end
        end
        default: begin
          running_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // A reset action flushes the queue and wins over any pop in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < LAP_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (reset_req) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= lap_entry;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign sw_start_o     = start_q;
  assign sw_stop_o      = stop_q;
  assign sw_reset_o     = ~resetn_i | rst_pulse_q;
  assign running_o      = running_q;
  assign lap_valid_o    = (count_q != '0);
  assign lap_data_o     = mem_q[rd_ptr_q];
  assign lap_count_o    = count_q;
  assign lap_overflow_o = overflow_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// tb/tb_stopwatch_lap_ctrl.sv - directed self-checking bench for stopwatch_lap_ctrl
module tb_stopwatch_lap_ctrl;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          resetn, btn_ss, btn_lr, lap_ready;
  logic [DW-1:0] sw_count;
  logic          sw_start, sw_stop, sw_reset, running, lap_valid, lap_overflow;
  logic [DW-1:0] lap_data;
  logic [2:0]    lap_count;

  int passed = 0;
  int total  = 0;

  stopwatch_lap_ctrl #(.DATA_WIDTH(DW), .MAX(99), .LAP_DEPTH(4)) dut (
    .clk_i(clk), .resetn_i(resetn), .btn_ss_i(btn_ss), .btn_lr_i(btn_lr),
    .sw_count_i(sw_count), .sw_start_o(sw_start), .sw_stop_o(sw_stop),
    .sw_reset_o(sw_reset), .running_o(running), .lap_valid_o(lap_valid),
    .lap_data_o(lap_data), .lap_ready_i(lap_ready), .lap_count_o(lap_count),
    .lap_overflow_o(lap_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

`ifdef STOPWATCH_LAP_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  task automatic lap(input logic [DW-1:0] cnt, input logic rdy);
    sw_count = cnt; btn_lr = 1'b1; lap_ready = rdy;
    tick();
    btn_lr = 1'b0; lap_ready = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] drain_exp [4];
    resetn = 1'b0; btn_ss = 1'b0; btn_lr = 1'b0; lap_ready = 1'b0; sw_count = '0;

    tick(); tick();
    check("rst_sw_reset", sw_reset, 1);
    check("rst_start", sw_start, 0);
    check("rst_stop", sw_stop, 0);
    check("rst_running", running, 0);
    check("rst_lap_valid", lap_valid, 0);
    check("rst_lap_data", lap_data, 0);
    check("rst_lap_count", lap_count, 0);
    check("rst_overflow", lap_overflow, 0);

    resetn = 1'b1;
    tick();
    check("rel_sw_reset", sw_reset, 0);

    btn_ss = 1'b1; tick(); btn_ss = 1'b0;
    check("start_pulse", sw_start, 1);
    check("start_running", running, 1);
    tick();
    check("start_pulse_end", sw_start, 0);
    check("run_running", running, 1);

    lap(16'd37, 1'b0);
    check("lap37_valid", lap_valid, 1);
    check("lap37_data", lap_data, 37);
    check("lap37_count", lap_count, 1);
    lap_ready = 1'b1; tick(); lap_ready = 1'b0;
    check("pop_valid", lap_valid, 0);
    check("pop_count", lap_count, 0);

    lap(16'd12, 1'b0);
    check("lap12_data", lap_data, SPLIT ? 75 : 12);
    lap_ready = 1'b1; tick(); lap_ready = 1'b0;

    lap(16'd10, 1'b0); lap(16'd20, 1'b0); lap(16'd30, 1'b0); lap(16'd40, 1'b0);
    check("full_count", lap_count, 4);
    check("full_no_ovf", lap_overflow, 0);
    check("full_head", lap_data, SPLIT ? 98 : 10);
    lap(16'd50, 1'b1);
    check("full_pop_push_count", lap_count, 4);
    check("full_pop_push_ovf", lap_overflow, 0);
    lap(16'd60, 1'b0);
    check("drop_count", lap_count, 4);
    check("drop_ovf", lap_overflow, 1);

    if (SPLIT) begin
      drain_exp[0] = 16'd10; drain_exp[1] = 16'd10; drain_exp[2] = 16'd10; drain_exp[3] = 16'd10;
    end else begin
      drain_exp[0] = 16'd20; drain_exp[1] = 16'd30; drain_exp[2] = 16'd40; drain_exp[3] = 16'd50;
    end
    lap_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_valid", i), lap_valid, 1);
      check($sformatf("drain%0d_data", i), lap_data, drain_exp[i]);
      tick();
    end
    check("drained_valid", lap_valid, 0);
    tick();
    check("empty_pop_count", lap_count, 0);
    lap_ready = 1'b0;
    check("ovf_sticky", lap_overflow, 1);

    sw_count = 16'd50; btn_ss = 1'b1; btn_lr = 1'b1;
    tick(); btn_ss = 1'b0; btn_lr = 1'b0;
    check("both_run_stop", sw_stop, 1);
    check("both_run_start", sw_start, 0);
    check("both_run_running", running, 0);
    check("both_run_count", lap_count, 1);
    check("both_run_data", lap_data, SPLIT ? 90 : 50);
    tick();
    check("both_run_stop_end", sw_stop, 0);

    btn_ss = 1'b1; tick(); btn_ss = 1'b0;
    check("resume_start", sw_start, 1);
    lap(16'd70, 1'b0);
    btn_ss = 1'b1; tick(); btn_ss = 1'b0;
    check("pause2_count", lap_count, 2);
    check("pause2_ovf", lap_overflow, 1);

    btn_ss = 1'b1; btn_lr = 1'b1; lap_ready = 1'b1;
    tick(); btn_ss = 1'b0; btn_lr = 1'b0; lap_ready = 1'b0;
    check("both_pause_reset", sw_reset, 1);
    check("both_pause_start", sw_start, 0);
    check("both_pause_running", running, 0);
    check("both_pause_valid", lap_valid, 0);
    check("both_pause_count", lap_count, 0);
    check("both_pause_ovf", lap_overflow, 0);
    tick();
    check("both_pause_reset_end", sw_reset, 0);

    btn_lr = 1'b1; tick(); btn_lr = 1'b0;
    check("idle_reset_pulse", sw_reset, 1);
    check("idle_reset_running", running, 0);
    btn_ss = 1'b1; tick(); btn_ss = 1'b0;
    check("idle_start", sw_start, 1);
    lap(16'd5, 1'b0);
    check("post_reset_lap", lap_data, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
